// File: rtl/pht_port_sched.sv
// PHT port scheduler: table clear after reset, lookup/update arbitration with
// anti-starvation, and serialized read-modify-write of queued counter updates.
// Optional build macro BPU_PERF_CNT_EN enables the perf_* event counters.
module pht_port_sched #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lk_valid,
  input  logic [31:0]                lk_pc,
  input  logic [IDX_W-1:0]           lk_ghr,
  output logic                       lk_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       ex_valid,
  input  logic [31:0]                ex_pc,
  input  logic [IDX_W-1:0]           ex_ghr,
  input  logic                       ex_taken,
  output logic                       ex_ready,
  output logic                       pht_en,
  output logic                       pht_we,
  output logic [IDX_W-1:0]           pht_addr,
  output logic [1:0]                 pht_wdata,
  input  logic [1:0]                 pht_rdata,
  output logic                       init_done,
  output logic                       overflow,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic [31:0]                perf_lookups,
  output logic [31:0]                perf_updates,
  output logic [31:0]                perf_drops
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] sweep_q;
  logic             init_done_q;
  logic [1:0]       cnt_q;
  logic [SW-1:0]    starve_q;
  logic             pred_valid_q;
  logic             overflow_q;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [IDX_W:0]   fifo_q [QDEPTH];

  logic             upd_req, force_upd, lk_grant, upd_grant;
  logic             full, push, pop, drop;
  logic [IDX_W-1:0] lk_idx, ex_idx, head_idx;
  logic             head_taken;
  logic [1:0]       next_cnt;
  logic             en_c, we_c;
  logic [IDX_W-1:0] addr_c;
  logic [1:0]       wdata_c;
  logic             unused_pc_hi;

  assign unused_pc_hi = ^{lk_pc[31:IDX_W], ex_pc[31:IDX_W]};

  assign lk_idx     = lk_pc[IDX_W-1:0] ^ lk_ghr;
  assign ex_idx     = ex_pc[IDX_W-1:0] ^ ex_ghr;
  assign head_idx   = fifo_q[rd_ptr_q][IDX_W-1:0];
  assign head_taken = fifo_q[rd_ptr_q][IDX_W];

  assign upd_req   = (state_q == S_RD) || (state_q == S_WR);
  assign force_upd = upd_req && (starve_q == SW'(STARVE_MAX));
  assign lk_grant  = init_done_q && lk_valid && !force_upd;
  assign upd_grant = upd_req && (!lk_valid || force_upd);

  assign full    = (count_q == CW'(QDEPTH));
  assign push    = ex_valid && !full;
  assign drop    = ex_valid && full;
  assign pop     = upd_grant && (state_q == S_WR);
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    next_cnt = cnt_q;
    if (head_taken) begin
      if (cnt_q != 2'd3) next_cnt = cnt_q + 2'd1;
    end else begin
      if (cnt_q != 2'd0) next_cnt = cnt_q - 2'd1;
    end
  end

  always_comb begin
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    if (state_q == S_INIT) begin
      en_c   = 1'b1;
      we_c   = 1'b1;
      addr_c = sweep_q;
    end else if (lk_grant) begin
      en_c   = 1'b1;
      addr_c = lk_idx;
    end else if (upd_grant) begin
      en_c    = 1'b1;
      we_c    = (state_q == S_WR);
      addr_c  = head_idx;
      wdata_c = next_cnt;
    end
  end

  // Port strobes are combinational from the current state, so hold them low
  // while reset is asserted to keep every output at zero during reset.
  assign pht_en     = en_c && !rst;
  assign pht_we     = we_c && !rst;
  assign pht_addr   = rst ? '0 : addr_c;
  assign pht_wdata  = rst ? '0 : wdata_c;
  assign lk_ready   = lk_grant;
  assign ex_ready   = !full && !rst;
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_valid_q && pht_rdata[1];
  assign init_done  = init_done_q;
  assign overflow   = overflow_q;
  assign q_count    = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      init_done_q  <= 1'b0;
      cnt_q        <= '0;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      pred_valid_q <= lk_grant;
      count_q      <= count_d;
      if (drop) overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

      if (upd_grant)
        starve_q <= '0;
      else if (upd_req && (starve_q != SW'(STARVE_MAX)))
        starve_q <= starve_q + SW'(1);

      case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + IDX_W'(1);
          if (sweep_q == '1) begin
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_IDLE: if (count_q != '0) state_q <= S_RD;
        S_RD:   if (upd_grant) state_q <= S_CAP;
        S_CAP: begin
          cnt_q   <= pht_rdata;
          state_q <= S_WR;
        end
        S_WR:   if (upd_grant) state_q <= (count_d != '0) ? S_RD : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {ex_taken, ex_idx};
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lk_q, perf_upd_q, perf_drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lk_q   <= '0;
      perf_upd_q  <= '0;
      perf_drop_q <= '0;
    end else begin
      if (lk_grant) perf_lk_q   <= perf_lk_q + 32'd1;
      if (pop)      perf_upd_q  <= perf_upd_q + 32'd1;
      if (drop)     perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_lookups = perf_lk_q;
  assign perf_updates = perf_upd_q;
  assign perf_drops   = perf_drop_q;
`else
  assign perf_lookups = '0;
  assign perf_updates = '0;
  assign perf_drops   = '0;
`endif

endmodule

// File: tb/tb_pht_port_sched.sv
// Directed bench for pht_port_sched with a behavioural single-port PHT memory.
module tb_pht_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic [3:0]  lk_ghr;
  logic        lk_ready, pred_valid, pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_ghr;
  logic        ex_taken, ex_ready;
  logic        pht_en, pht_we;
  logic [3:0]  pht_addr;
  logic [1:0]  pht_wdata, pht_rdata;
  logic        init_done, overflow;
  logic [2:0]  q_count;
  logic [31:0] perf_lookups, perf_updates, perf_drops;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [1:0] mem [16];
  logic [1:0] rdata_q;
  logic [1:0] wlog [$];

  always #5 clk = ~clk;

  pht_port_sched #(.IDX_W(4), .QDEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ghr(lk_ghr), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ghr(ex_ghr), .ex_taken(ex_taken),
    .ex_ready(ex_ready),
    .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr), .pht_wdata(pht_wdata),
    .pht_rdata(pht_rdata),
    .init_done(init_done), .overflow(overflow), .q_count(q_count),
    .perf_lookups(perf_lookups), .perf_updates(perf_updates), .perf_drops(perf_drops)
  );

  always @(posedge clk) begin
    if (pht_en) begin
      if (pht_we) mem[pht_addr] <= pht_wdata;
      else        rdata_q <= mem[pht_addr];
    end
    if (pht_en && pht_we && init_done) wlog.push_back(pht_wdata);
  end
  assign pht_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_upd(input logic [31:0] pc, input logic taken);
    ex_valid = 1'b1;
    ex_pc    = pc;
    ex_ghr   = 4'h0;
    ex_taken = taken;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q_count == 3'd0) break;
      tick();
    end
    repeat (4) tick();
    chk("drain_empty", q_count, 0);
  endtask

  initial begin
    rst = 1'b1; lk_valid = 1'b0; lk_pc = '0; lk_ghr = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_ghr = '0; ex_taken = 1'b0;
    repeat (3) tick();

    chk("rst_init_done", init_done, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_pht_en", pht_en, 0);
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_perf", perf_lookups | perf_updates | perf_drops, 0);

    // Table clear: one zero write per cycle to 0..15, then init_done.
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("init_wr", {pht_en, pht_we, pht_wdata, pht_addr}, {1'b1, 1'b1, 2'b00, 4'(i)});
      chk("init_not_done", init_done, 0);
      chk("init_lk_ready", lk_ready, 0);
      tick();
    end
    chk("init_done_rise", init_done, 1);

    // Lookup pc=5 ghr=3 -> index 6.
    lk_valid = 1'b1; lk_pc = 32'h5; lk_ghr = 4'h3;
    #1;
    chk("lk_ready", lk_ready, 1);
    chk("lk_addr", {pht_en, pht_we, pht_addr}, {1'b1, 1'b0, 4'd6});
    tick();
    lk_valid = 1'b0;
    #1;
    chk("pred_valid_n1", pred_valid, 1);
    chk("pred_taken_init", pred_taken, 0);
    tick();
    chk("pred_valid_drop", pred_valid, 0);

    // Three back-to-back taken updates to index 6.
    wlog.delete();
    push_upd(32'h6, 1'b1); tick();
    tick();
    tick();
    ex_valid = 1'b0;
    #1;
    chk("q_count_3", q_count, 3);
    repeat (12) tick();
    chk("upd_log_len", wlog.size(), 3);
    chk("upd_wr_1", wlog[0], 1);
    chk("upd_wr_2", wlog[1], 2);
    chk("upd_wr_3", wlog[2], 3);

    lk_valid = 1'b1; lk_pc = 32'h6; lk_ghr = 4'h0;
    tick();
    lk_valid = 1'b0;
    #1;
    chk("pred_taken_sat", {pred_valid, pred_taken}, 2'b11);

    // Saturation at 3, decrement, and saturation at 0.
    push_upd(32'h6, 1'b1); tick();
    ex_valid = 1'b0;
    repeat (8) tick();
    chk("sat_hi_len", wlog.size(), 4);
    chk("sat_hi_wr", wlog[3], 3);
    push_upd(32'h6, 1'b0); tick();
    push_upd(32'h0, 1'b0); tick();
    ex_valid = 1'b0;
    repeat (14) tick();
    chk("dec_len", wlog.size(), 6);
    chk("dec_wr", wlog[4], 2);
    chk("sat_lo_wr", wlog[5], 0);

    // Starvation: update loses three cycles, wins on the fourth (read and write).
    lk_valid = 1'b1; lk_pc = 32'h1; lk_ghr = 4'h0;
    push_upd(32'h6, 1'b0);
    #1;
    chk("stv_push_lk", lk_ready, 1);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("stv_idle_lk", lk_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stv_rd_lose", lk_ready, 1);
    end
    tick();
    chk("stv_rd_force", {lk_ready, pht_en, pht_we, pht_addr}, {1'b0, 1'b1, 1'b0, 4'd6});
    tick();
    chk("stv_cap_lk", lk_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stv_wr_lose", lk_ready, 1);
    end
    tick();
    chk("stv_wr_force", {lk_ready, pht_en, pht_we, pht_addr, pht_wdata},
        {1'b0, 1'b1, 1'b1, 4'd6, 2'd1});
    tick();
    lk_valid = 1'b0;
    chk("stv_q_empty", q_count, 0);

    // Overflow: five pushes while updates are stalled by lookups.
    lk_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_upd(32'(i), 1'b1);
      #1;
      if (i < 5) chk("ovf_ready", ex_ready, 1);
      else       chk("ovf_full", {ex_ready, q_count}, {1'b0, 3'd4});
      tick();
    end
    ex_valid = 1'b0;
    #1;
    chk("ovf_sticky", overflow, 1);
    chk("ovf_q_count", q_count, 4);
`ifdef BPU_PERF_CNT_EN
    chk("ovf_perf_drops", perf_drops, 1);
`endif
    lk_valid = 1'b0;
    drain();
    chk("ovf_still_set", overflow, 1);

    // Reset during CAP with two entries queued.
    push_upd(32'h2, 1'b1); tick();
    push_upd(32'h3, 1'b1); tick();
    ex_valid = 1'b0;
    #1;
    chk("rmw_rd_count", q_count, 2);
    tick();
    chk("rmw_cap_count", q_count, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_q_count", q_count, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_pht_en", pht_en, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("reinit_addr0", {pht_en, pht_we, pht_addr}, {1'b1, 1'b1, 4'd0});
    tick();
    chk("reinit_addr1", {pht_en, pht_we, pht_addr}, {1'b1, 1'b1, 4'd1});
    repeat (14) tick();
    chk("reinit_not_done", init_done, 0);
    tick();
    chk("reinit_done", init_done, 1);
`ifndef BPU_PERF_CNT_EN
    chk("perf_tied_zero", perf_lookups | perf_updates | perf_drops, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pht_port_sched.md
Name: pht_port_sched

Overview:
- Scheduler and sequencer for a single-ported, synchronous-read 2-bit-counter pattern history table (PHT) in the RV32I branch predictor.
- Arbitrates the one PHT port between fetch-stage lookups and execute-stage counter updates.
- Buffers resolved-branch updates in a small FIFO and performs each update as a serialized read-modify-write.
- Clears the table after reset.

Parameters:
- IDX_W, 4, PHT index width; table depth 2**IDX_W.
- QDEPTH, 4, update FIFO entries (power of 2, >=2).
- STARVE_MAX, 3, max consecutive cycles a port-waiting update may lose to lookups.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- lk_valid  in  1  fetch lookup request
- lk_pc  in  32  fetch PC
- lk_ghr  in  IDX_W  global history at fetch
- lk_ready  out  1  lookup granted this cycle
- pred_valid  out  1  prediction valid
- pred_taken  out  1  predicted direction
- ex_valid  in  1  resolved branch
- ex_pc  in  32  resolved branch PC
- ex_ghr  in  IDX_W  history carried down the pipe
- ex_taken  in  1  actual outcome
- ex_ready  out  1  FIFO not full
- pht_en  out  1  port enable
- pht_we  out  1  write enable
- pht_addr  out  IDX_W  port address
- pht_wdata  out  2  write data
- pht_rdata  in  2  read data, valid the cycle after pht_en && !pht_we
- init_done  out  1  table clear finished
- overflow  out  1  sticky: update dropped
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy
- perf_lookups  out  32  see Optional Feature
- perf_updates  out  32  see Optional Feature
- perf_drops  out  32  see Optional Feature

Behaviour:
- Index = pc[IDX_W-1:0] XOR ghr, for both lookup and update.
- Reset values: all outputs 0, FIFO empty, starve counter 0, FSM in INIT with sweep address 0.
- INIT:
  - One write per cycle: addr = sweep, wdata = 2'b00.
  - 2**IDX_W cycles, then init_done=1 and FSM goes to IDLE.
  - lk_ready=0 throughout; ex pushes are accepted.
- Update FSM states:
  - IDLE: go to RD when FIFO is non-empty.
  - RD: needs the port; when granted, read the head entry's index, then go to CAP.
  - CAP: no port use; capture pht_rdata into cnt_q, then go to WR.
  - WR: needs the port; when granted, write the saturating next value and pop the FIFO. Next state is RD if FIFO is still non-empty, else IDLE.
- Saturating next value: taken → min(cnt+1, 3); not taken → max(cnt-1, 0).
- Arbitration, per cycle, after init:
  - Lookup wins by default: lk_ready = lk_valid && !force.
  - force = (starve_cnt == STARVE_MAX) && FSM in RD or WR.
  - The update is granted when the FSM is in RD or WR and (!lk_valid || force).
- Starve counter:
  - Increments each cycle the FSM is in RD/WR and loses the port.
  - Clears on any update grant.
  - Saturates at STARVE_MAX.
- Lookup latency: a granted lookup in cycle N gives pred_valid=1 in N+1, with pred_taken = pht_rdata[1]. pred_valid=0 otherwise.
- FIFO:
  - ex_ready = !full, from registered occupancy.
  - Push when ex_valid && ex_ready; pop on WR grant.
  - Push and pop in the same cycle: q_count unchanged.
  - ex_valid while full: entry dropped, overflow set until reset.
- Update ordering and hazards:
  - Updates to the same index are serialized; the second RD follows the first WR, so no lost increments.
  - A lookup between an update's RD and WR reads the pre-update value. This is accepted behaviour, not forwarded.
- Reset mid-operation:
  - FIFO contents discarded.
  - An in-flight RMW is abandoned.
  - INIT restarts from index 0.

Optional Feature:
- Macro: BPU_PERF_CNT_EN.
- Defined:
  - perf_lookups counts granted lookups.
  - perf_updates counts WR grants.
  - perf_drops counts dropped pushes.
  - All 32-bit, wrap on overflow, reset to 0.
- Undefined: all three ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then idle → init_done rises exactly 16 cycles after rst deasserts (IDX_W=4). Every write during INIT has wdata=0 at addr 0..15.
- After init, lookup pc=0x5, ghr=0x3 (idx 6) → pht_addr=6, pred_valid in the next cycle, pred_taken=0.
- Three taken updates to idx 6, then lookup idx 6 → write data sequence 1, 2, 3; pred_taken=1. A fourth taken update writes 3 (saturation).
- lk_valid held high with one queued update, STARVE_MAX=3 → update loses 3 cycles, lk_ready=0 on the 4th, and the update read issues that cycle.
- Push 5 updates back-to-back with lk_valid held high (updates stalled) → ex_ready=0 after 4 pushes, 5th dropped, overflow=1, q_count=4. With BPU_PERF_CNT_EN, perf_drops=1.
- Assert rst during CAP with q_count=2 → q_count=0, init_done=0, and INIT restarts at addr 0.
